// File: rtl/fft_result_buffer_pkg.sv
// Shared types and register map for the FFT result capture buffer.
// Bus offsets are byte addresses within the 4 KiB peripheral window.
package fft_result_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } fft_buf_state_e;

    localparam logic [11:0] FFTBUF_CTRL   = 12'h000;
    localparam logic [11:0] FFTBUF_STATUS = 12'h004;
    localparam logic [11:0] FFTBUF_NPTS   = 12'h008;
    localparam logic [11:0] FFTBUF_DATA   = 12'h800;

    localparam int CTRL_ARM_BIT    = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_ABORT_BIT  = 2;
    localparam int CTRL_IRQ_EN_BIT = 3;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 16;

    function automatic logic [31:0] pack_result(input logic [15:0] re, input logic [15:0] im);
        return {im, re};
    endfunction

endpackage

// File: rtl/fft_result_ram.sv
// Result storage: one synchronous write port and one registered read port.
// A read and write to the same address in one cycle returns the old word.
module fft_result_ram
    import fft_result_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/fft_result_buffer.sv
// Captures one frame of FFT output samples and exposes it, plus control and
// status registers, on the data-memory bus with one-cycle registered reads.
module fft_result_buffer
    import fft_result_buffer_pkg::*;
#(
    parameter int   NPOINTS = 64,
    parameter int   DATA_W  = 16,
    parameter logic BITREV  = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [11:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic              stream_valid_i,
    input  logic [DATA_W-1:0] stream_r_i,
    input  logic [DATA_W-1:0] stream_i_i,
    output logic              irq_o,
    output logic              busy_o
);

    localparam int          AW     = $clog2(NPOINTS);
    localparam int          CW     = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NPOINTS - 1);
    localparam logic [9:0]  NPTS10 = 10'(NPOINTS);

    fft_buf_state_e state_q;
    logic [CW-1:0]  count_q;
    logic           done_q;
    logic           ovf_q;
    logic           irq_en_q;
    logic           irq_q;
    logic           busy_q;
    logic           rd_sel_ram_q;
    logic [31:0]    reg_rdata_q;
    logic [31:0]    reg_rdata_d;
    logic [31:0]    ram_rdata;

    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = v[AW-1-b];
        end
        return r;
    endfunction

    // Bus decode; the low two address bits are ignored.
    logic [8:0] data_idx;
    logic       is_ctrl, is_status, is_npts, is_data;
    logic       rd_en, ctrl_wr;
    assign data_idx  = addr_i[10:2];
    assign is_ctrl   = (addr_i[11:2] == FFTBUF_CTRL[11:2]);
    assign is_status = (addr_i[11:2] == FFTBUF_STATUS[11:2]);
    assign is_npts   = (addr_i[11:2] == FFTBUF_NPTS[11:2]);
    assign is_data   = addr_i[11] && ({1'b0, data_idx} < NPTS10);
    assign rd_en     = en_i && (we_i == 4'b0000);
    assign ctrl_wr   = en_i && (we_i != 4'b0000) && is_ctrl;

    logic cmd_arm, cmd_clr, cmd_abort;
    assign cmd_abort = ctrl_wr && data_i[CTRL_ABORT_BIT];
    assign cmd_arm   = ctrl_wr && data_i[CTRL_ARM_BIT] && !data_i[CTRL_ABORT_BIT];
    assign cmd_clr   = ctrl_wr && data_i[CTRL_CLR_BIT];

    logic capture_en, drop;
    assign capture_en = stream_valid_i && ((state_q == ARMED) || (state_q == CAPTURE));
    assign drop       = stream_valid_i && !capture_en;

    logic signed [15:0] re16, im16;
    logic [AW-1:0]      wr_idx;
    assign re16   = 16'($signed(stream_r_i));
    assign im16   = 16'($signed(stream_i_i));
    assign wr_idx = BITREV ? bit_reverse(count_q[AW-1:0]) : count_q[AW-1:0];

    fft_result_ram #(
        .DEPTH (NPOINTS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (capture_en),
        .waddr_i (wr_idx),
        .wdata_i (pack_result(re16, im16)),
        .re_i    (rd_en && is_data),
        .raddr_i (data_idx[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Count is reported in an 8-bit field; a 256-point frame clamps at 255.
    logic [7:0] count_rpt;
    assign count_rpt = (32'(count_q) > 32'd255) ? 8'hFF : 8'(count_q);

    always_comb begin
        reg_rdata_d = 32'h0;
        if (is_ctrl) begin
            reg_rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
        end else if (is_status) begin
            reg_rdata_d[STAT_BUSY_BIT]                     = busy_q;
            reg_rdata_d[STAT_DONE_BIT]                     = done_q;
            reg_rdata_d[STAT_OVF_BIT]                      = ovf_q;
            reg_rdata_d[STAT_COUNT_LSB+7:STAT_COUNT_LSB]   = count_rpt;
        end else if (is_npts) begin
            reg_rdata_d = 32'(NPOINTS);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_ram_q <= 1'b0;
            reg_rdata_q  <= 32'h0;
        end else if (rd_en) begin
            rd_sel_ram_q <= is_data;
            reg_rdata_q  <= reg_rdata_d;
        end
    end

    assign data_o = rd_sel_ram_q ? ram_rdata : reg_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= data_i[CTRL_IRQ_EN_BIT];
            end
            irq_q <= done_q && irq_en_q;
            if (cmd_clr) begin
                done_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_arm) begin
                        state_q <= ARMED;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (cmd_abort) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (stream_valid_i) begin
                        state_q <= CAPTURE;
                        count_q <= CW'(1);
                    end
                end
                CAPTURE: begin
                    if (cmd_abort) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (stream_valid_i) begin
                        count_q <= count_q + CW'(1);
                        if (count_q == LAST_IDX) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (cmd_arm) begin
                        state_q <= ARMED;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (cmd_clr) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase

            // A dropped sample wins over an ARM/CLR clear in the same cycle.
            if (cmd_clr || (cmd_arm && ((state_q == IDLE) || (state_q == DONE)))) begin
                ovf_q <= 1'b0;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign irq_o  = irq_q;
    assign busy_o = busy_q;

    logic unused_bits;
    assign unused_bits = ^{data_i[31:4], addr_i[1:0]};

endmodule

// File: tb/tb_fft_result_buffer.sv
// Randomized bench for the FFT result buffer: a 64-point natural-order
// instance and an 8-point bit-reversed instance share the bus wires.
module tb_fft_result_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en0, en1;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        sv0, sv1;
    logic [15:0] sr, si;
    logic [31:0] dout0, dout1;
    logic        irq0, irq1, busy0, busy1;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_mem [64];
    logic [31:0] rd;

    always #5 clk = ~clk;

    fft_result_buffer #(.NPOINTS(64), .DATA_W(16), .BITREV(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .en_i(en0), .we_i(we), .addr_i(addr),
        .data_i(wdata), .data_o(dout0), .stream_valid_i(sv0),
        .stream_r_i(sr), .stream_i_i(si), .irq_o(irq0), .busy_o(busy0)
    );

    fft_result_buffer #(.NPOINTS(8), .DATA_W(16), .BITREV(1'b1)) dut_br (
        .clk(clk), .reset_n(reset_n), .en_i(en1), .we_i(we), .addr_i(addr),
        .data_i(wdata), .data_o(dout1), .stream_valid_i(sv1),
        .stream_r_i(sr), .stream_i_i(si), .irq_o(irq1), .busy_o(busy1)
    );

    // All tasks start and end at a falling edge.
    task automatic bus_write(input int sel, input logic [11:0] a, input logic [31:0] d);
        en0 = (sel == 0); en1 = (sel == 1); we = 4'hF; addr = a; wdata = d;
        @(negedge clk);
        en0 = 1'b0; en1 = 1'b0; we = 4'h0;
    endtask

    task automatic bus_read(input int sel, input logic [11:0] a, output logic [31:0] d);
        en0 = (sel == 0); en1 = (sel == 1); we = 4'h0; addr = a;
        @(negedge clk);
        en0 = 1'b0; en1 = 1'b0;
        d = (sel == 0) ? dout0 : dout1;
    endtask

    task automatic stream_sample(input int sel, input logic [15:0] r, input logic [15:0] i);
        sv0 = (sel == 0); sv1 = (sel == 1); sr = r; si = i;
        @(negedge clk);
        sv0 = 1'b0; sv1 = 1'b0;
    endtask

    function automatic logic [31:0] status_word(input int cnt, input bit busy, input bit done, input bit ovf);
        return (32'(cnt) << 16) | (32'(ovf) << 2) | (32'(done) << 1) | 32'(busy);
    endfunction

    task automatic test_reset();
        n_vec++; if ({busy0, irq0, dout0} !== 34'h0) begin n_err++;
            $display("FAIL reset_outputs got busy=%0b irq=%0b data=%h want 0", busy0, irq0, dout0); end
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_status got %h want 0", rd); end
        bus_read(0, 12'h008, rd);
        n_vec++; if (rd !== 32'd64) begin n_err++; $display("FAIL npoints got %h want 40", rd); end
        bus_read(0, 12'h00C, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped got %h want 0", rd); end
        bus_read(0, 12'h900, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL beyond_frame got %h want 0", rd); end
        $display("reset: checks done");
    endtask

    task automatic test_capture();
        bus_write(0, 12'h000, 32'h9);
        bus_read(0, 12'h000, rd);
        n_vec++; if (rd !== 32'h8) begin n_err++; $display("FAIL ctrl_readback got %h want 8", rd); end
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(0, 1, 0, 0)) begin n_err++; $display("FAIL armed_status got %h want 1", rd); end
        for (int k = 0; k < 64; k++) begin
            exp_mem[k] = {16'(-k), 16'(k)};
            sv0 = 1'b1; sr = 16'(k); si = 16'(-k);
            @(negedge clk);
        end
        sv0 = 1'b0;
        n_vec++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq_early got %b want 0", irq0); end
        @(negedge clk);
        n_vec++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL irq_late got %b want 1", irq0); end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL busy_after_done got %b want 0", busy0); end
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== 32'h00400002) begin n_err++; $display("FAIL done_status got %h want 00400002", rd); end
        bus_read(0, 12'h814, rd);
        n_vec++; if (rd !== 32'hFFFB0005) begin n_err++; $display("FAIL result5 got %h want FFFB0005", rd); end
        bus_write(0, 12'h004, 32'hFFFFFFFF);
        bus_write(0, 12'h814, 32'h12345678);
        n_vec++; if (dout0 !== 32'hFFFB0005) begin n_err++; $display("FAIL data_hold got %h want FFFB0005", dout0); end
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== 32'h00400002) begin n_err++; $display("FAIL ro_write_status got %h want 00400002", rd); end
        for (int k = 0; k < 64; k++) begin
            bus_read(0, 12'h800 + 12'(4 * k), rd);
            n_vec++; if (rd !== exp_mem[k]) begin n_err++;
                $display("FAIL capture_result[%0d] got %h want %h", k, rd, exp_mem[k]); end
        end
        $display("capture: 64 contiguous samples checked");
    endtask

    task automatic test_gaps();
        logic [15:0] r, i;
        bus_write(0, 12'h000, 32'h1);
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(0, 1, 0, 0)) begin n_err++; $display("FAIL rearm_status got %h want 1", rd); end
        for (int k = 0; k < 64; k++) begin
            r = 16'($urandom); i = 16'($urandom);
            exp_mem[k] = {i, r};
            stream_sample(0, r, i);
            bus_read(0, 12'h004, rd);
            n_vec++; if (rd !== status_word(k + 1, k < 63, k == 63, 0)) begin n_err++;
                $display("FAIL gap_status[%0d] got %h want %h", k, rd, status_word(k + 1, k < 63, k == 63, 0)); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (k == 30) bus_write(0, 12'h000, 32'h1);
        end
        n_vec++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq_disabled got %b want 0", irq0); end
        for (int k = 0; k < 64; k++) begin
            bus_read(0, 12'h800 + 12'(4 * k), rd);
            n_vec++; if (rd !== exp_mem[k]) begin n_err++;
                $display("FAIL gap_result[%0d] got %h want %h", k, rd, exp_mem[k]); end
        end
        $display("gaps: 64 spaced samples checked");
    endtask

    task automatic test_overflow();
        bus_write(0, 12'h000, 32'h2);
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL clr_status got %h want 0", rd); end
        for (int k = 0; k < 3; k++) stream_sample(0, 16'($urandom), 16'($urandom));
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(0, 0, 0, 1)) begin n_err++; $display("FAIL ovf_status got %h want 4", rd); end
        for (int k = 0; k < 3; k++) begin
            bus_read(0, 12'h800 + 12'(4 * k), rd);
            n_vec++; if (rd !== exp_mem[k]) begin n_err++;
                $display("FAIL ovf_unchanged[%0d] got %h want %h", k, rd, exp_mem[k]); end
        end
        bus_write(0, 12'h000, 32'h2);
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL ovf_clear got %h want 0", rd); end
        $display("overflow: idle drops checked");
    endtask

    task automatic test_arm_with_valid();
        logic [15:0] r, i;
        r = 16'($urandom); i = 16'($urandom);
        en0 = 1'b1; we = 4'hF; addr = 12'h000; wdata = 32'h1; sv0 = 1'b1; sr = r; si = i;
        @(negedge clk);
        en0 = 1'b0; we = 4'h0; sv0 = 1'b0;
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(0, 1, 0, 1)) begin n_err++; $display("FAIL arm_valid_status got %h want 5", rd); end
        r = 16'($urandom); i = 16'($urandom);
        stream_sample(0, r, i);
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(1, 1, 0, 1)) begin n_err++; $display("FAIL arm_valid_first got %h want 00010005", rd); end
        bus_read(0, 12'h800, rd);
        n_vec++; if (rd !== {i, r}) begin n_err++; $display("FAIL arm_valid_result got %h want %h", rd, {i, r}); end
        bus_write(0, 12'h000, 32'h4);
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(0, 0, 0, 1)) begin n_err++; $display("FAIL abort_keep_ovf got %h want 4", rd); end
        bus_write(0, 12'h000, 32'h2);
        $display("arm_with_valid: same-cycle command checked");
    endtask

    task automatic test_abort();
        logic [15:0] r, i;
        bus_write(0, 12'h000, 32'h1);
        for (int k = 0; k < 10; k++) begin
            r = 16'($urandom); i = 16'($urandom);
            exp_mem[k] = {i, r};
            stream_sample(0, r, i);
        end
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(10, 1, 0, 0)) begin n_err++; $display("FAIL abort_pre got %h want 000A0001", rd); end
        bus_write(0, 12'h000, 32'h5);
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy0); end
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL abort_status got %h want 0", rd); end
        stream_sample(0, 16'($urandom), 16'($urandom));
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(0, 0, 0, 1)) begin n_err++; $display("FAIL abort_ovf got %h want 4", rd); end
        for (int k = 0; k < 10; k++) begin
            bus_read(0, 12'h800 + 12'(4 * k), rd);
            n_vec++; if (rd !== exp_mem[k]) begin n_err++;
                $display("FAIL abort_result[%0d] got %h want %h", k, rd, exp_mem[k]); end
        end
        bus_write(0, 12'h000, 32'h2);
        $display("abort: partial frame checked");
    endtask

    task automatic test_async_reset();
        logic [15:0] r, i;
        bus_write(0, 12'h000, 32'h9);
        for (int k = 0; k < 20; k++) begin
            r = 16'($urandom_range(1, 65535)); i = 16'($urandom);
            exp_mem[k] = {i, r};
            stream_sample(0, r, i);
        end
        bus_read(0, 12'h800, rd);
        n_vec++; if (rd !== exp_mem[0]) begin n_err++; $display("FAIL prereset_result got %h want %h", rd, exp_mem[0]); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if ({busy0, irq0, dout0} !== 34'h0) begin n_err++;
            $display("FAIL async_reset got busy=%0b irq=%0b data=%h want 0", busy0, irq0, dout0); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL post_reset_status got %h want 0", rd); end
        bus_read(0, 12'h000, rd);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL post_reset_ctrl got %h want 0", rd); end
        bus_write(0, 12'h000, 32'h1);
        for (int k = 0; k < 5; k++) begin
            r = 16'($urandom); i = 16'($urandom);
            exp_mem[k] = {i, r};
            stream_sample(0, r, i);
        end
        bus_read(0, 12'h004, rd);
        n_vec++; if (rd !== status_word(5, 1, 0, 0)) begin n_err++; $display("FAIL rearm_count got %h want 00050001", rd); end
        for (int k = 0; k < 5; k++) begin
            bus_read(0, 12'h800 + 12'(4 * k), rd);
            n_vec++; if (rd !== exp_mem[k]) begin n_err++;
                $display("FAIL rearm_result[%0d] got %h want %h", k, rd, exp_mem[k]); end
        end
        $display("async_reset: mid-capture reset checked");
    endtask

    task automatic test_bitrev();
        int          rev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        logic [15:0] im [8];
        logic [31:0] want;
        bus_read(1, 12'h008, rd);
        n_vec++; if (rd !== 32'd8) begin n_err++; $display("FAIL br_npoints got %h want 8", rd); end
        bus_write(1, 12'h000, 32'h1);
        for (int k = 0; k < 8; k++) begin
            im[k] = 16'($urandom);
            stream_sample(1, 16'(k), im[k]);
        end
        bus_read(1, 12'h004, rd);
        n_vec++; if (rd !== status_word(8, 0, 1, 0)) begin n_err++; $display("FAIL br_status got %h want 00080002", rd); end
        for (int j = 0; j < 8; j++) begin
            want = {im[rev8[j]], 16'(rev8[j])};
            bus_read(1, 12'h800 + 12'(4 * j), rd);
            n_vec++; if (rd !== want) begin n_err++;
                $display("FAIL br_result[%0d] got %h want %h", j, rd, want); end
        end
        $display("bitrev: 8-point reorder checked");
    endtask

    initial begin
        reset_n = 1'b0;
        en0 = 1'b0; en1 = 1'b0; we = 4'h0; addr = 12'h0; wdata = 32'h0;
        sv0 = 1'b0; sv1 = 1'b0; sr = 16'h0; si = 16'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_capture();
        test_gaps();
        test_overflow();
        test_arm_with_valid();
        test_abort();
        test_async_reset();
        test_bitrev();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
